// File: rtl/vinsn_dispatcher_pkg.sv
// Shared types and helpers for the vector instruction dispatch slice.
// Contents: the decoded-insn, VFU-request and operand-request payloads,
// the VFU and vector-op enumerations, the instruction id type and the
// helper functions that map an op to its VFU, a register to its VRF
// address and an op to its operand queues. dispatch_entry_t is the FIFO
// entry type used by vinsn_fifo.
// Ports: none (package).
package vinsn_dispatcher_pkg;

  localparam int unsigned NrVFU     = 4;
  localparam int unsigned InsnIDNum = 8;

  typedef logic [$clog2(InsnIDNum)-1:0] insn_id_t;
  typedef logic [4:0]                   vreg_t;
  typedef logic [7:0]                   vaddr_t;

  typedef enum logic [1:0] {
    VFU_ALU   = 2'd0,
    VFU_MFPU  = 2'd1,
    VFU_LOAD  = 2'd2,
    VFU_STORE = 2'd3
  } vfu_e;

  typedef enum logic [2:0] {
    VADD  = 3'd0,
    VSUB  = 3'd1,
    VAND  = 3'd2,
    VOR   = 3'd3,
    VMUL  = 3'd4,
    VMACC = 3'd5,
    VLE   = 3'd6,
    VSE   = 3'd7
  } vop_e;

  // use_vs[0] enables vs1, use_vs[1] enables vs2.
  typedef struct packed {
    insn_id_t   id;
    vop_e       vop;
    vreg_t      vd;
    vreg_t      vs1;
    vreg_t      vs2;
    logic [1:0] use_vs;
  } issue_req_t;

  typedef struct packed {
    insn_id_t   id;
    vop_e       vop;
    vaddr_t     waddr;
    logic [1:0] use_vs;
  } vfu_req_t;

  typedef struct packed {
    insn_id_t   id;
    logic [3:0] queue_req;
    vreg_t      vs1;
    vreg_t      vs2;
  } op_req_t;

  typedef struct packed {
    issue_req_t payload;
  } dispatch_entry_t;

  function automatic vfu_e GetVFUByVOp(input vop_e vop);
    vfu_e v;
    case (vop)
      VMUL, VMACC: v = VFU_MFPU;
      VLE:         v = VFU_LOAD;
      VSE:         v = VFU_STORE;
      default:     v = VFU_ALU;
    endcase
    return v;
  endfunction

  // Each vector register owns an 8-word slice of the VRF.
  function automatic vaddr_t GetVRFAddr(input vreg_t vd);
    return {vd, 3'b000};
  endfunction

  // Queue bits [1:0] feed the ALU operand ports, [3:2] the MFPU ports;
  // stores stream only their data register through queue 0.
  function automatic logic [3:0] GetOpQueue(input vop_e vop, input logic [1:0] use_vs);
    logic [3:0] q;
    case (vop)
      VMUL, VMACC: q = {use_vs, 2'b00};
      VLE:         q = 4'b0000;
      VSE:         q = {3'b000, use_vs[0]};
      default:     q = {2'b00, use_vs};
    endcase
    return q;
  endfunction

endpackage

// File: rtl/vinsn_fifo.sv
// Instruction FIFO for the dispatcher: storage, wrap-around pointers and
// occupancy count, plus a flush that can keep a partially dispatched head.
// Ports:
//   clk_i, rst_ni     clock, asynchronous active-low reset
//   push_i, data_i    enqueue request and entry (ignored when full or flushing)
//   pop_i             dequeue the head (ignored when empty)
//   flush_i           drop every entry, except the head when keep_head_i is set
//   keep_head_i       head has started dispatch and must survive a flush
//   head_o            current head entry
//   empty_o, full_o   occupancy flags
//   count_o           occupancy
module vinsn_fifo
  import vinsn_dispatcher_pkg::*;
#(
  parameter int unsigned Depth = 4,
  parameter int unsigned CntW  = $clog2(Depth + 1)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            push_i,
  input  dispatch_entry_t data_i,
  input  logic            pop_i,
  input  logic            flush_i,
  input  logic            keep_head_i,
  output dispatch_entry_t head_o,
  output logic            empty_o,
  output logic            full_o,
  output logic [CntW-1:0] count_o
);

  localparam int unsigned PtrW = $clog2(Depth);

  dispatch_entry_t mem_q [Depth];
  logic [PtrW-1:0] rptr_q, rptr_d;
  logic [PtrW-1:0] wptr_q, wptr_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CntW'(Depth));
  assign count_o = cnt_q;
  assign head_o  = mem_q[rptr_q];

  assign do_push = push_i && !full_o && !flush_i;
  assign do_pop  = pop_i && !empty_o;

  // Depth is a power of two, so pointer overflow is the modulo wrap.
  always_comb begin
    rptr_d = rptr_q;
    wptr_d = wptr_q;
    cnt_d  = cnt_q;
    if (do_pop) rptr_d = rptr_q + PtrW'(1);
    if (flush_i) begin
      if (keep_head_i && !empty_o && !do_pop) begin
        wptr_d = rptr_q + PtrW'(1);
        cnt_d  = CntW'(1);
      end else begin
        wptr_d = rptr_d;
        cnt_d  = '0;
      end
    end else begin
      if (do_push) wptr_d = wptr_q + PtrW'(1);
      cnt_d = cnt_q + CntW'(do_push) - CntW'(do_pop);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rptr_q <= '0;
      wptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      rptr_q <= rptr_d;
      wptr_q <= wptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Payload storage needs no reset: it is only read while counted valid.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= data_i;
  end

endmodule

// File: rtl/vinsn_dispatcher.sv
// Vector instruction dispatcher. Buffers decoded insns in a FIFO and issues
// the head as one VFU request and one operand request with independent
// handshakes; the head pops once both have been accepted.
// Handshake rule for every interface: a transfer happens on a cycle where
// valid and ready are both high; valid never depends on ready, and once
// raised it holds with a stable payload until the transfer.
// Optional feature macro: VINSN_DISPATCH_HAZARD_EN adds an in-flight
// register interlock (busy bit + destination register per insn id).
// Ports:
//   clk_i, rst_ni                  clock, asynchronous active-low reset
//   issue_req_valid_i/_ready_o/_i  insn input from the decoder
//   flush_i                        drop queued insns that have not started
//   vfu_req_ready_i                per-VFU ready
//   vfu_req_valid_o, target_vfu_o, vfu_req_o   head VFU request
//   op_req_ready_i, op_req_valid_o, op_req_o   head operand request
//   vfu_done_i, vfu_done_id_i      per-VFU completion strobe and id
//   count_o                        FIFO occupancy
module vinsn_dispatcher
  import vinsn_dispatcher_pkg::*;
#(
  parameter int unsigned QueueDepth = 4,
  parameter int unsigned NrVFUs     = NrVFU,
  parameter int unsigned CntW       = $clog2(QueueDepth + 1)
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      issue_req_valid_i,
  output logic                      issue_req_ready_o,
  input  issue_req_t                issue_req_i,
  input  logic                      flush_i,
  input  logic [NrVFUs-1:0]         vfu_req_ready_i,
  output logic                      vfu_req_valid_o,
  output vfu_e                      target_vfu_o,
  output vfu_req_t                  vfu_req_o,
  input  logic                      op_req_ready_i,
  output logic                      op_req_valid_o,
  output op_req_t                   op_req_o,
  input  logic [NrVFUs-1:0]         vfu_done_i,
  input  insn_id_t [NrVFUs-1:0]     vfu_done_id_i,
  output logic [CntW-1:0]           count_o
);

  dispatch_entry_t head, push_entry;
  issue_req_t      hd;
  logic            empty, full;
  logic            vfu_sent_q, vfu_sent_d;
  logic            op_sent_q, op_sent_d;
  logic            go;
  logic            vfu_ready_sel;
  logic            vfu_hs, op_hs, vfu_fin, op_fin, pop, started;

  assign push_entry.payload = issue_req_i;

  vinsn_fifo #(
    .Depth (QueueDepth),
    .CntW  (CntW)
  ) i_fifo (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .push_i      (issue_req_valid_i && issue_req_ready_o),
    .data_i      (push_entry),
    .pop_i       (pop),
    .flush_i     (flush_i),
    .keep_head_i (started),
    .head_o      (head),
    .empty_o     (empty),
    .full_o      (full),
    .count_o     (count_o)
  );

  assign hd = head.payload;

  // Ready is not pop-aware, and is withheld during a flush.
  assign issue_req_ready_o = !full && !flush_i;

  assign target_vfu_o = GetVFUByVOp(hd.vop);

  always_comb begin
    vfu_req_o        = '0;
    vfu_req_o.id     = hd.id;
    vfu_req_o.vop    = hd.vop;
    vfu_req_o.waddr  = GetVRFAddr(hd.vd);
    vfu_req_o.use_vs = hd.use_vs;
    op_req_o           = '0;
    op_req_o.id        = hd.id;
    op_req_o.queue_req = GetOpQueue(hd.vop, hd.use_vs);
    op_req_o.vs1       = hd.vs1;
    op_req_o.vs2       = hd.vs2;
  end

  always_comb begin
    vfu_ready_sel = 1'b0;
    for (int k = 0; k < NrVFUs; k++) begin
      if (int'(target_vfu_o) == k) vfu_ready_sel = vfu_req_ready_i[k];
    end
  end

  assign vfu_req_valid_o = !empty && go && !vfu_sent_q;
  assign op_req_valid_o  = !empty && go && !op_sent_q;

  assign vfu_hs  = vfu_req_valid_o && vfu_ready_sel;
  assign op_hs   = op_req_valid_o && op_req_ready_i;
  // "Finished" counts a handshake happening this very cycle.
  assign vfu_fin = vfu_sent_q || vfu_hs;
  assign op_fin  = op_sent_q || op_hs;
  assign pop     = !empty && vfu_fin && op_fin;
  // A head that has any handshake behind it (or in this cycle) survives flush.
  assign started = vfu_fin || op_fin;

  always_comb begin
    vfu_sent_d = vfu_fin;
    op_sent_d  = op_fin;
    if (pop || empty) begin
      vfu_sent_d = 1'b0;
      op_sent_d  = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vfu_sent_q <= 1'b0;
      op_sent_q  <= 1'b0;
    end else begin
      vfu_sent_q <= vfu_sent_d;
      op_sent_q  <= op_sent_d;
    end
  end

`ifdef VINSN_DISPATCH_HAZARD_EN
  logic [InsnIDNum-1:0] busy_q, busy_d;
  vreg_t                vd_tab_q [InsnIDNum];
  logic                 go_q, go_d;
  logic                 hazard;

  // RAW on enabled sources, WAW on the destination.
  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < InsnIDNum; i++) begin
      if (busy_q[i] && ((hd.use_vs[0] && vd_tab_q[i] == hd.vs1) ||
                        (hd.use_vs[1] && vd_tab_q[i] == hd.vs2) ||
                        (vd_tab_q[i] == hd.vd)))
        hazard = 1'b1;
    end
  end

  // Once raised, valids must not drop because the head's own vfu handshake
  // marks its destination busy; go_q freezes the decision.
  assign go = go_q || !hazard;

  always_comb begin
    busy_d = busy_q;
    for (int k = 0; k < NrVFUs; k++) begin
      if (vfu_done_i[k]) busy_d[vfu_done_id_i[k]] = 1'b0;
    end
    if (vfu_hs) busy_d[hd.id] = 1'b1;
    go_d = go_q;
    if (pop || (flush_i && !started) || empty) go_d = 1'b0;
    else if (go)                               go_d = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q <= '0;
      go_q   <= 1'b0;
    end else begin
      busy_q <= busy_d;
      go_q   <= go_d;
    end
  end

  // Only consulted while the matching busy bit is set.
  always_ff @(posedge clk_i) begin
    if (vfu_hs) vd_tab_q[hd.id] <= hd.vd;
  end
`else
  logic unused_done;
  assign go          = 1'b1;
  assign unused_done = ^{vfu_done_i, vfu_done_id_i};
`endif

endmodule
